// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle multiply/divide controller for the HI/LO register pair.
// MULT/MULTU: one cycle of product compute. DIV/DIVU: 32 restoring radix-2 steps.
// A one-cycle DONE state writes HI/LO. MTHI/MTLO write directly from IDLE.
module muldiv_hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_o,
    output logic        busy_o,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;          // multiplicand, or dividend shifting into quotient
    logic [31:0] b_q, b_d;          // multiplier, or divisor magnitude
    logic [31:0] rem_q, rem_d;      // partial remainder
    logic [4:0]  cnt_q, cnt_d;      // division iteration counter
    logic        sgn_q, sgn_d;      // signed multiply
    logic        negq_q, negq_d;    // negate quotient at the end
    logic        negr_q, negr_d;    // negate remainder at the end
    logic        div0_q, div0_d;    // divisor was zero
    logic [31:0] hi_res_q, hi_res_d;
    logic [31:0] lo_res_q, lo_res_d;

    logic        accept_s;
    logic [63:0] ext_a_s, ext_b_s, prod_s;
    logic [32:0] shifted_s, diff_s;
    logic [31:0] q_step_s, r_step_s;

    // Accept decode plus single-step datapath for multiply and restoring division.
    always_comb begin
        accept_s  = (state_q == S_IDLE) && op_valid && !flush && !rst && (op <= 3'd5);
        ext_a_s   = {{32{sgn_q & a_q[31]}}, a_q};
        ext_b_s   = {{32{sgn_q & b_q[31]}}, b_q};
        prod_s    = ext_a_s * ext_b_s;
        shifted_s = {rem_q, a_q[31]};
        diff_s    = shifted_s - {1'b0, b_q};
        q_step_s  = {a_q[30:0], ~diff_s[32]};
        r_step_s  = diff_s[32] ? shifted_s[31:0] : diff_s[31:0];
    end

    // Next-state and operand/result register updates.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sgn_d    = sgn_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        div0_d   = div0_q;
        hi_res_d = hi_res_q;
        lo_res_d = lo_res_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && (op <= 3'd1)) begin
                    a_d     = src_a;
                    b_d     = src_b;
                    sgn_d   = (op == 3'd0);
                    state_d = S_MUL;
                end else if (accept_s && (op <= 3'd3)) begin
                    // Signed division works on magnitudes; signs are fixed up at the end.
                    sgn_d   = (op == 3'd2);
                    negq_d  = (op == 3'd2) & (src_a[31] ^ src_b[31]);
                    negr_d  = (op == 3'd2) & src_a[31];
                    div0_d  = (src_b == 32'd0);
                    a_d     = ((op == 3'd2) && src_a[31]) ? (32'd0 - src_a) : src_a;
                    b_d     = ((op == 3'd2) && src_b[31]) ? (32'd0 - src_b) : src_b;
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_res_d = prod_s[63:32];
                    lo_res_d = prod_s[31:0];
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    a_d   = q_step_s;
                    rem_d = r_step_s;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        // A zero divisor leaves the dividend magnitude in the remainder,
                        // so the sign fix-up restores the raw dividend.
                        lo_res_d = div0_q ? 32'hFFFF_FFFF :
                                   (negq_q ? (32'd0 - q_step_s) : q_step_s);
                        hi_res_d = negr_q ? (32'd0 - r_step_s) : r_step_s;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rem_q    <= 32'd0;
            cnt_q    <= 5'd0;
            sgn_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_res_q <= 32'd0;
            lo_res_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sgn_q    <= sgn_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            div0_q   <= div0_d;
            hi_res_q <= hi_res_d;
            lo_res_q <= lo_res_d;
        end
    end

    // Pipeline stall, busy and HI/LO write port; all quiet while reset is held.
    always_comb begin
        stall_o  = 1'b0;
        busy_o   = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = 32'd0;
        lo_wdata = 32'd0;
        if (!rst) begin
            stall_o = (accept_s && !op[2]) ||
                      (((state_q == S_MUL) || (state_q == S_DIV)) && !flush);
            busy_o  = (state_q != S_IDLE);
            if (accept_s && (op == 3'd4)) begin
                hi_we    = 1'b1;
                hi_wdata = src_a;
            end else if (accept_s && (op == 3'd5)) begin
                lo_we    = 1'b1;
                lo_wdata = src_a;
            end else if ((state_q == S_DONE) && !flush) begin
                hi_we    = 1'b1;
                lo_we    = 1'b1;
                hi_wdata = hi_res_q;
                lo_wdata = lo_res_q;
            end else begin
                hi_we = 1'b0;
            end
        end else begin
            stall_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: directed scenarios plus random ops against an arithmetic model.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    int checks   = 0;
    int failures = 0;

    muldiv_hilo_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    // Expected HI/LO from plain integer arithmetic.
    task automatic model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        eh = 32'd0;
        el = 32'd0;
        if (mop == 3'd0) begin
            sp = longint'(sa) * longint'(sb);
            eh = sp[63:32];
            el = sp[31:0];
        end else if (mop == 3'd1) begin
            up = {32'd0, a} * {32'd0, b};
            eh = up[63:32];
            el = up[31:0];
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
        end else if (mop == 3'd2) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                el = 32'h8000_0000;
                eh = 32'd0;
            end else begin
                el = sa / sb;
                eh = sa % sb;
            end
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_stall, input logic e_busy,
                           input logic e_hwe, input logic e_lwe,
                           input logic [31:0] e_hd, input logic [31:0] e_ld);
        chk({tag, ".stall"}, {31'd0, stall_o}, {31'd0, e_stall});
        chk({tag, ".busy"},  {31'd0, busy_o},  {31'd0, e_busy});
        chk({tag, ".hi_we"}, {31'd0, hi_we},   {31'd0, e_hwe});
        chk({tag, ".lo_we"}, {31'd0, lo_we},   {31'd0, e_lwe});
        chk({tag, ".hi_wd"}, hi_wdata, e_hd);
        chk({tag, ".lo_wd"}, lo_wdata, e_ld);
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic r);
        @(negedge clk);
        op_valid = v;
        op       = o;
        src_a    = a;
        src_b    = b;
        flush    = fl;
        rst      = r;
        #1;
    endtask

    // Multiply/divide with the instruction held; abort_k>0 flushes (or resets) at that stall cycle.
    task automatic do_long(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int abort_k, input logic abort_rst);
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        model(o, a, b, eh, el);
        n = (o < 3'd2) ? 2 : 33;
        drive(1'b1, o, a, b, 1'b0, 1'b0);
        chk_all("accept", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= n; k++) begin
            if (k == abort_k) begin
                drive(1'b1, o, a, b, !abort_rst, abort_rst);
                if (abort_rst)
                    chk_all("rst_abort", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                else
                    chk_all("flush_abort", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
                drive(1'b0, o, a, b, 1'b0, 1'b0);
                chk_all("after_abort", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                return;
            end
            drive(1'b1, o, a, b, 1'b0, 1'b0);
            if (k < n)
                chk_all("busy", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            else
                chk_all("done", 1'b0, 1'b1, 1'b1, 1'b1, eh, el);
        end
        drive(1'b0, o, a, b, 1'b0, 1'b0);
        chk_all("post_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // MTHI/MTLO/reserved op in IDLE, optionally with flush.
    task automatic do_single(input logic [2:0] o, input logic [31:0] a, input logic fl);
        logic eh;
        logic el;
        eh = !fl && (o == 3'd4);
        el = !fl && (o == 3'd5);
        drive(1'b1, o, a, $urandom, fl, 1'b0);
        chk_all("single", 1'b0, 1'b0, eh, el, eh ? a : 32'd0, el ? a : 32'd0);
        drive(1'b0, o, a, 32'd0, 1'b0, 1'b0);
        chk_all("single_next", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          ak;

        rst = 1'b1; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
        drive(1'b1, 3'd2, 32'd100, 32'd3, 1'b0, 1'b1);
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 3'd4, 32'h55, 32'd3, 1'b0, 1'b1);
        chk_all("reset_mthi", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        do_long(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        do_long(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 1'b0);
        do_long(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_long(3'd3, 32'd7, 32'd0, 0, 1'b0);
        do_long(3'd2, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
        do_long(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_long(3'd2, 32'd100, 32'hFFFF_FFFD, 0, 1'b0);
        do_long(3'd2, 32'd100, 32'd3, 11, 1'b0);
        do_single(3'd5, 32'h1234, 1'b0);
        do_long(3'd2, 32'd100, 32'd3, 21, 1'b1);
        do_long(3'd3, 32'd9, 32'd4, 0, 1'b0);
        do_long(3'd0, 32'd5, 32'd6, 2, 1'b0);
        do_long(3'd3, 32'd50, 32'd6, 33, 1'b0);
        do_single(3'd6, 32'hDEAD_BEEF, 1'b0);
        do_single(3'd7, 32'hCAFE_0001, 1'b0);
        do_single(3'd4, 32'hA5A5_0F0F, 1'b1);

        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else rb = rb;
            if (ro <= 3'd3) begin
                ak = ($urandom_range(0, 7) == 0) ? $urandom_range(1, (ro < 3'd2) ? 2 : 33) : 0;
                do_long(ro, ra, rb, ak, 1'($urandom_range(0, 1)));
            end else begin
                do_single(ro, ra, $urandom_range(0, 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
